// File: rtl/fifo_word_writer_pkg.sv
// Shared sizing constants and state type for the byte-serialising FIFO writer.
package fifo_word_writer_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned MAX_BYTES  = 2;
  localparam int unsigned CNT_WIDTH  = $clog2(MAX_BYTES + 1);
  localparam int unsigned PTR_WIDTH  = 4;
  localparam int unsigned IN_WIDTH   = DATA_WIDTH * MAX_BYTES;

  typedef enum logic {StIdle, StSend} wr_state_e;

  // Out-of-range byte counts fall back to a full word so a load never yields zero bytes.
  function automatic logic [CNT_WIDTH-1:0] eff_bytes(input logic [CNT_WIDTH-1:0] n);
    if (n == '0 || n > CNT_WIDTH'(MAX_BYTES)) begin
      return CNT_WIDTH'(MAX_BYTES);
    end
    return n;
  endfunction

endpackage

// File: rtl/fifo_word_holder.sv
// Holding register for one input word with a byte-index mux and remaining-byte count.
module fifo_word_holder
  import fifo_word_writer_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic                  advance_i,
  input  logic [IN_WIDTH-1:0]   data_i,
  input  logic [CNT_WIDTH-1:0]  bytes_i,
  output logic [DATA_WIDTH-1:0] byte_o,
  output logic                  last_o
);

  logic [IN_WIDTH-1:0]  data_q, data_d;
  logic [CNT_WIDTH-1:0] idx_q, idx_d;
  logic [CNT_WIDTH-1:0] rem_q, rem_d;

  // Load takes priority: on a back-to-back accept the final byte goes out as the new word loads.
  always_comb begin
    data_d = data_q;
    idx_d  = idx_q;
    rem_d  = rem_q;
    if (load_i) begin
      data_d = data_i;
      idx_d  = '0;
      rem_d  = bytes_i;
    end else if (advance_i) begin
      idx_d = idx_q + 1'b1;
      rem_d = rem_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
      idx_q  <= '0;
      rem_q  <= '0;
    end else begin
      data_q <= data_d;
      idx_q  <= idx_d;
      rem_q  <= rem_d;
    end
  end

  always_comb begin
    byte_o = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      if (idx_q == CNT_WIDTH'(i)) begin
        byte_o = data_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign last_o = (rem_q == CNT_WIDTH'(1));

endmodule

// File: rtl/fifo_word_writer.sv
// Accepts multi-byte words on valid/ready and writes them LSB-byte-first into a byte-wide FIFO.
module fifo_word_writer
  import fifo_word_writer_pkg::*;
(
  input  logic                  W_CLK,
  input  logic                  W_RST,
  input  logic [IN_WIDTH-1:0]   IN_DATA,
  input  logic [CNT_WIDTH-1:0]  IN_BYTES,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic                  FULL,
  output logic                  W_INC,
  output logic [DATA_WIDTH-1:0] W_DATA,
  output logic                  WORD_DONE,
  output logic                  BUSY
);

  wr_state_e state_q, state_d;
  logic      done_q, done_d;
  logic      last;
  logic      accept;
  logic      wr_en;

  fifo_word_holder u_holder (
    .clk_i     (W_CLK),
    .rst_i     (W_RST),
    .load_i    (accept),
    .advance_i (wr_en),
    .data_i    (IN_DATA),
    .bytes_i   (eff_bytes(IN_BYTES)),
    .byte_o    (W_DATA),
    .last_o    (last)
  );

  // Ready is gated by reset so nothing is offered while the block is held in reset.
  always_comb begin
    wr_en    = (state_q == StSend) && !FULL;
    IN_READY = !W_RST &&
               ((state_q == StIdle) || ((state_q == StSend) && last && !FULL));
    accept   = IN_VALID && IN_READY;
    done_d   = wr_en && last;
    state_d  = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StSend;
      StSend: if (wr_en && last) state_d = accept ? StSend : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge W_CLK or posedge W_RST) begin
    if (W_RST) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  assign W_INC     = wr_en;
  assign WORD_DONE = done_q;
  assign BUSY      = (state_q == StSend);

endmodule

// File: tb/tb_fifo_word_writer.sv
// Directed bench for fifo_word_writer: per-cycle vector table plus stall, stream and reset sequences.
module tb_fifo_word_writer;

  logic        w_clk = 1'b0;
  logic        w_rst;
  logic [15:0] in_data;
  logic [1:0]  in_bytes;
  logic        in_valid;
  logic        in_ready;
  logic        full;
  logic        w_inc;
  logic [7:0]  w_data;
  logic        word_done;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        valid;
    logic [15:0] data;
    logic [1:0]  bytes;
    logic        full;
    logic        e_ready;
    logic        e_winc;
    logic [7:0]  e_wdata;
    logic        e_done;
    logic        e_busy;
  } vec_t;

  vec_t vq[$];

  fifo_word_writer dut (
    .W_CLK     (w_clk),
    .W_RST     (w_rst),
    .IN_DATA   (in_data),
    .IN_BYTES  (in_bytes),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .FULL      (full),
    .W_INC     (w_inc),
    .W_DATA    (w_data),
    .WORD_DONE (word_done),
    .BUSY      (busy)
  );

  always #5 w_clk = ~w_clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic v, input logic [15:0] d, input logic [1:0] b, input logic f,
                     input logic r, input logic w, input logic [7:0] wd, input logic dn,
                     input logic bs);
    vq.push_back('{v, d, b, f, r, w, wd, dn, bs});
  endtask

  logic [15:0] words[5];
  logic [1:0]  nbytes[5];
  logic [7:0]  byte_q[$];
  logic [7:0]  exp_b;
  int          wi;
  int          written;
  int          exp_total;
  int          n;
  logic        finished;

  initial begin
    // A55A/2: two bytes, single done pulse, ready during the second byte.
    add(1, 16'hA55A, 2, 0, 1, 0, 8'h00, 0, 0);
    add(0, 16'h0000, 0, 0, 0, 1, 8'h5A, 0, 1);
    add(0, 16'h0000, 0, 0, 1, 1, 8'hA5, 0, 1);
    add(0, 16'h0000, 0, 0, 1, 0, 8'h00, 1, 0);
    add(0, 16'h0000, 0, 0, 1, 0, 8'h00, 0, 0);
    // 1122/2 then 3344/1 with no bubble.
    add(1, 16'h1122, 2, 0, 1, 0, 8'h00, 0, 0);
    add(1, 16'h3344, 1, 0, 0, 1, 8'h22, 0, 1);
    add(1, 16'h3344, 1, 0, 1, 1, 8'h11, 0, 1);
    add(0, 16'h0000, 0, 0, 1, 1, 8'h44, 1, 1);
    add(0, 16'h0000, 0, 0, 1, 0, 8'h00, 1, 0);
    add(0, 16'h0000, 0, 0, 1, 0, 8'h00, 0, 0);
    // BEEF/2 with FULL held for 4 cycles; offered data during the stall must be ignored.
    add(1, 16'hBEEF, 2, 0, 1, 0, 8'h00, 0, 0);
    add(0, 16'h0000, 0, 0, 0, 1, 8'hEF, 0, 1);
    for (int i = 0; i < 4; i++) add(1, 16'h1234, 2, 1, 0, 0, 8'h00, 0, 1);
    add(0, 16'h0000, 0, 0, 1, 1, 8'hBE, 0, 1);
    add(0, 16'h0000, 0, 0, 1, 0, 8'h00, 1, 0);
    // Invalid byte counts 0 and 3 both behave as 2.
    add(1, 16'hCAFE, 0, 0, 1, 0, 8'h00, 0, 0);
    add(0, 16'h0000, 0, 0, 0, 1, 8'hFE, 0, 1);
    add(0, 16'h0000, 0, 0, 1, 1, 8'hCA, 0, 1);
    add(0, 16'h0000, 0, 0, 1, 0, 8'h00, 1, 0);
    add(1, 16'h5678, 3, 0, 1, 0, 8'h00, 0, 0);
    add(0, 16'h0000, 0, 0, 0, 1, 8'h78, 0, 1);
    add(0, 16'h0000, 0, 0, 1, 1, 8'h56, 0, 1);
    add(0, 16'h0000, 0, 0, 1, 0, 8'h00, 1, 0);

    // Reset state with a word already offered.
    w_rst    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'hA55A;
    in_bytes = 2'd2;
    full     = 1'b0;
    repeat (2) @(posedge w_clk);
    @(negedge w_clk);
    check("rst_in_ready", {15'd0, in_ready}, 16'd0);
    check("rst_w_inc", {15'd0, w_inc}, 16'd0);
    check("rst_w_data", {8'd0, w_data}, 16'd0);
    check("rst_word_done", {15'd0, word_done}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    @(posedge w_clk);
    #1;
    w_rst    = 1'b0;
    in_valid = 1'b0;
    @(posedge w_clk);
    @(negedge w_clk);
    check("post_rst_ready", {15'd0, in_ready}, 16'd1);

    foreach (vq[i]) begin
      @(posedge w_clk);
      #1;
      in_valid = vq[i].valid;
      in_data  = vq[i].data;
      in_bytes = vq[i].bytes;
      full     = vq[i].full;
      @(negedge w_clk);
      check($sformatf("v%0d_in_ready", i), {15'd0, in_ready}, {15'd0, vq[i].e_ready});
      check($sformatf("v%0d_w_inc", i), {15'd0, w_inc}, {15'd0, vq[i].e_winc});
      if (vq[i].e_winc) check($sformatf("v%0d_w_data", i), {8'd0, w_data}, {8'd0, vq[i].e_wdata});
      check($sformatf("v%0d_word_done", i), {15'd0, word_done}, {15'd0, vq[i].e_done});
      check($sformatf("v%0d_busy", i), {15'd0, busy}, {15'd0, vq[i].e_busy});
    end

    // FULL alternating every cycle over 5 random words; scoreboard on the byte stream.
    for (int i = 0; i < 5; i++) begin
      words[i]  = 16'($urandom);
      nbytes[i] = 2'($urandom_range(0, 3));
    end
    wi = 0; written = 0; exp_total = 0; finished = 1'b0;
    for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
      @(posedge w_clk);
      #1;
      full     = (cyc % 2 == 0);
      in_valid = (wi < 5);
      if (wi < 5) begin
        in_data  = words[wi];
        in_bytes = nbytes[wi];
      end
      @(negedge w_clk);
      if (full) check("winc_while_full", {15'd0, w_inc}, 16'd0);
      if (w_inc) begin
        if (byte_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL stream_extra_byte: got %h expected no write", w_data);
        end else begin
          exp_b = byte_q.pop_front();
          check("stream_byte", {8'd0, w_data}, {8'd0, exp_b});
        end
        written++;
      end
      if (in_valid && in_ready) begin
        n = (nbytes[wi] == 2'd0 || nbytes[wi] == 2'd3) ? 2 : int'(nbytes[wi]);
        for (int k = 0; k < n; k++) byte_q.push_back(words[wi][8*k +: 8]);
        exp_total += n;
        wi++;
      end
      finished = (wi == 5) && (byte_q.size() == 0);
    end
    check("stream_finished", {15'd0, finished}, 16'd1);
    check("stream_count", 16'(written), 16'(exp_total));

    // Reset after the first byte of 0102: partial word is dropped.
    @(posedge w_clk);
    #1;
    in_valid = 1'b0;
    full     = 1'b0;
    repeat (2) @(posedge w_clk);
    #1;
    in_valid = 1'b1;
    in_data  = 16'h0102;
    in_bytes = 2'd2;
    @(posedge w_clk);
    #1;
    in_valid = 1'b0;
    @(negedge w_clk);
    check("mid_first_winc", {15'd0, w_inc}, 16'd1);
    check("mid_first_byte", {8'd0, w_data}, 16'h0002);
    @(posedge w_clk);
    #1;
    check("mid_second_pending", {15'd0, w_inc}, 16'd1);
    w_rst = 1'b1;
    #1;
    check("mid_rst_w_inc", {15'd0, w_inc}, 16'd0);
    check("mid_rst_busy", {15'd0, busy}, 16'd0);
    check("mid_rst_word_done", {15'd0, word_done}, 16'd0);
    check("mid_rst_in_ready", {15'd0, in_ready}, 16'd0);
    repeat (2) @(posedge w_clk);
    @(negedge w_clk);
    #1;
    w_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge w_clk);
      check("after_rst_w_inc", {15'd0, w_inc}, 16'd0);
      check("after_rst_busy", {15'd0, busy}, 16'd0);
      check("after_rst_in_ready", {15'd0, in_ready}, 16'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_word_writer.md
Name: fifo_word_writer

Overview:
- Write-domain stage directly upstream of the async FIFO write pointer handler.
- Accepts multi-byte words (e.g. 16-bit ALU results) on a valid/ready interface and serialises them LSB-byte-first into the byte-wide async FIFO.
- Drives the FIFO write strobe and write data, and honours the handler's FULL flag.
- Guarantees no byte is lost or duplicated under backpressure.

Parameters:
- DATA_WIDTH, 8, FIFO entry width in bits.
- MAX_BYTES, 2, maximum bytes per input word; IN_DATA width = DATA_WIDTH*MAX_BYTES.
- CNT_WIDTH, $clog2(MAX_BYTES+1), width of byte-count fields.

Ports:
- W_CLK  input  1  write-domain clock.
- W_RST  input  1  asynchronous, active-high reset.
- IN_DATA  input  DATA_WIDTH*MAX_BYTES  word to send; byte 0 = bits [DATA_WIDTH-1:0].
- IN_BYTES  input  CNT_WIDTH  number of valid bytes in IN_DATA, 1..MAX_BYTES.
- IN_VALID  input  1  word offered.
- IN_READY  output  1  word accepted this cycle when IN_VALID && IN_READY.
- FULL  input  1  FIFO full flag from the write pointer handler, same clock.
- W_INC  output  1  FIFO write strobe.
- W_DATA  output  DATA_WIDTH  FIFO write data, valid when W_INC=1.
- WORD_DONE  output  1  one-cycle pulse when the last byte of a word is written.
- BUSY  output  1  holding a word with bytes remaining.

Behaviour:
- Reset (W_RST=1, asynchronous): state IDLE; holding register, remaining count and byte index cleared.
  - Outputs during reset: IN_READY=0, W_INC=0, W_DATA=0, WORD_DONE=0, BUSY=0.
  - After release: IN_READY=1 on the first clock edge.
- States:
  - IDLE: IN_READY=1, W_INC=0. On accept, load the holding register with IN_DATA, set remaining = IN_BYTES, index = 0, and go to SEND.
  - SEND: W_INC = ~FULL (combinational). W_DATA = holding byte[index] (combinational mux from registered state).
- On each SEND cycle with W_INC=1: index+1, remaining-1.
- When remaining==1 and W_INC=1, the word completes:
  - WORD_DONE pulses (registered, one cycle after that write).
  - IN_READY=1 in that same cycle, so back-to-back acceptance is allowed.
  - If a new word is accepted, reload and stay in SEND with no bubble.
  - Otherwise go to IDLE.
- IN_READY = (state==IDLE) || (state==SEND && remaining==1 && ~FULL).
- Throughput: one byte per cycle while FULL=0. Latency from accept to first W_INC is 1 cycle.
- FULL=1 in SEND: W_INC=0; index, remaining and holding register are frozen; IN_READY=0. Resume on the first cycle FULL=0.
- FULL toggling every cycle: each byte is written exactly once, in order.
- Invalid IN_BYTES (0 or >MAX_BYTES): treated as MAX_BYTES. Never writes zero bytes; never stalls.
- IN_DATA and IN_BYTES are sampled only on accept. Changes while not accepted are ignored.
- No W_INC is ever driven while FULL=1. The pointer handler also gates it; this block must not rely on that gating.
- Reset mid-word: the partial word is discarded and no further W_INC is issued. The FIFO pointers are reset by their own domain reset.
- BUSY = (state==SEND).

Decomposition:
- Shared parameters package holds:
  - DATA_WIDTH, MAX_BYTES, CNT_WIDTH (alongside PTR_WIDTH).
  - An enum typedef for the writer state {IDLE, SEND}.
- One sub-module: fifo_word_holder.
  - Holding register plus byte-index mux.
  - Exposes the current byte and a last-byte flag.
  - Controlled by load and advance strobes.
- The FSM and handshake stay in the top module.

Test Plan:
- Reset release, IN_VALID=1, IN_DATA=16'hA55A, IN_BYTES=2, FULL=0 -> W_INC high for 2 cycles, W_DATA=8'h5A then 8'hA5; WORD_DONE pulses once; IN_READY high during the 2nd byte.
- Back-to-back words 16'h1122/2 then 16'h3344/1, FULL=0 -> W_DATA sequence 22,11,44 on 3 consecutive cycles with no bubble; 2 WORD_DONE pulses.
- Word 16'hBEEF/2, FULL=1 for 4 cycles after the first byte -> EF written, W_INC=0 and IN_READY=0 for 4 cycles, then BE written; no duplicate.
- FULL alternating 1/0 every cycle over 5 words of random data -> scoreboard gets every byte exactly once, in order; W_INC never 1 while FULL=1.
- IN_BYTES=0 with IN_DATA=16'hCAFE -> treated as 2: FE then CA written.
- W_RST asserted after the first byte of 16'h0102 -> W_INC, BUSY and WORD_DONE go 0 asynchronously; after release, IDLE with IN_READY=1 and byte 01 never written.
